// File: rtl/mw_input_conditioner_pkg.sv
// Shared constants for the microwave input conditioner and controller.
// Defaults, setting widths and level encodings live here.
package mw_input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMER_W_DEF         = 7;
    localparam int TIMER_MAX_DEF       = 99;

    localparam logic PWR_HALF    = 1'b0;
    localparam logic PWR_FULL    = 1'b1;
    localparam logic DOOR_OPEN   = 1'b0;
    localparam logic DOOR_CLOSED = 1'b1;

    function automatic int unsigned clamp_u(
        input int unsigned v,
        input int unsigned max
    );
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/mw_input_conditioner_if.sv
// Bundle between raw pads / controller and the input conditioner.
// slave = conditioner side, master = pad/controller side.
interface mw_input_conditioner_if
    import mw_input_conditioner_pkg::*;
#(
    parameter int TIMER_W = TIMER_W_DEF
);
    logic               start_button_raw;
    logic               cancel_button_raw;
    logic               door_status_raw;
    logic               power_raw;
    logic [TIMER_W-1:0] timer_raw;
    logic               load_en;
    logic               start_pulse;
    logic               cancel_pulse;
    logic               door_closed;
    logic               door_open_evt;
    logic               power_q;
    logic [TIMER_W-1:0] timer_q;
    logic               timer_valid;

    modport master (
        output start_button_raw, cancel_button_raw, door_status_raw,
        output power_raw, timer_raw, load_en,
        input  start_pulse, cancel_pulse, door_closed, door_open_evt,
        input  power_q, timer_q, timer_valid
    );

    modport slave (
        input  start_button_raw, cancel_button_raw, door_status_raw,
        input  power_raw, timer_raw, load_en,
        output start_pulse, cancel_pulse, door_closed, door_open_evt,
        output power_q, timer_q, timer_valid
    );

endinterface

// File: rtl/mw_input_conditioner_debounce.sv
// 2-flop synchronizer plus counter debounce for one raw level.
// rise_o/fall_o flag the edge on which stable_o is about to change.
module mw_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] LAST = 8'(CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       stable_q;
    logic       stable_d;
    logic       synced;
    logic       differ;
    logic       flip;

    assign synced = sync_q[1];
    assign differ = synced ^ stable_q;
    assign flip   = differ && (cnt_q == LAST);

    always_comb begin
        cnt_d    = (differ && !flip) ? cnt_q + 8'd1 : 8'd0;
        stable_d = flip ? synced : stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            cnt_q    <= 8'd0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = flip & synced;
    assign fall_o   = flip & ~synced;

endmodule

// File: rtl/mw_input_conditioner.sv
// Debounced button events, door level and clamped setting capture
// feeding the microwave controller.
module mw_input_conditioner
    import mw_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMER_W         = TIMER_W_DEF,
    parameter int TIMER_MAX       = TIMER_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    mw_input_conditioner_if.slave bus
);

    logic start_lvl, start_rise, start_fall;
    logic cancel_lvl, cancel_rise, cancel_fall;
    logic door_lvl, door_rise, door_fall;

    mw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (bus.start_button_raw),
        .stable_o (start_lvl),
        .rise_o   (start_rise),
        .fall_o   (start_fall)
    );

    mw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (bus.cancel_button_raw),
        .stable_o (cancel_lvl),
        .rise_o   (cancel_rise),
        .fall_o   (cancel_fall)
    );

    mw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_door (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (bus.door_status_raw),
        .stable_o (door_lvl),
        .rise_o   (door_rise),
        .fall_o   (door_fall)
    );

    logic unused_lvls;
    assign unused_lvls = ^{start_lvl, start_fall, cancel_lvl, cancel_fall};

    logic               door_ok_d;
    logic               start_pulse_q, start_pulse_d;
    logic               cancel_pulse_q, cancel_pulse_d;
    logic               door_evt_q, door_evt_d;
    logic               power_q, power_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               valid_q, valid_d;
    logic [TIMER_W-1:0] timer_clamp;

    assign timer_clamp =
        TIMER_W'(clamp_u(32'(bus.timer_raw), TIMER_MAX));

    // Door level as it will read after this edge, so a press that
    // qualifies together with the door closing is still accepted.
    assign door_ok_d = (door_lvl & ~door_fall) | door_rise;

    always_comb begin
        start_pulse_d  = start_rise & door_ok_d & ~cancel_rise;
        cancel_pulse_d = cancel_rise;
        door_evt_d     = door_fall;
        power_d        = power_q;
        timer_d        = timer_q;
        valid_d        = valid_q;
        if (bus.load_en) begin
            power_d = bus.power_raw;
            timer_d = timer_clamp;
            valid_d = (timer_clamp != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_pulse_q  <= 1'b0;
            cancel_pulse_q <= 1'b0;
            door_evt_q     <= 1'b0;
            power_q        <= PWR_HALF;
            timer_q        <= '0;
            valid_q        <= 1'b0;
        end else begin
            start_pulse_q  <= start_pulse_d;
            cancel_pulse_q <= cancel_pulse_d;
            door_evt_q     <= door_evt_d;
            power_q        <= power_d;
            timer_q        <= timer_d;
            valid_q        <= valid_d;
        end
    end

    assign bus.start_pulse   = start_pulse_q;
    assign bus.cancel_pulse  = cancel_pulse_q;
    assign bus.door_closed   = door_lvl;
    assign bus.door_open_evt = door_evt_q;
    assign bus.power_q       = power_q;
    assign bus.timer_q       = timer_q;
    assign bus.timer_valid   = valid_q;

endmodule
